// File: rtl/fifo_mem_if.sv
// Handshake and status bundle between the FIFO control logic (master)
// and the storage/pointer stage (slave).
interface fifo_mem_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
);
   localparam int AW = $clog2(DEPTH);

   logic             mem_wr_en;
   logic             mem_rd_en;
   logic [WIDTH-1:0] fifo_wr_data;
   logic [WIDTH-1:0] fifo_rd_data;
   logic             mem_full;
   logic             mem_empty;
   logic             mem_wr_err;
   logic             mem_rd_err;
   logic [AW:0]      mem_count;

   modport master (
      output mem_wr_en, mem_rd_en, fifo_wr_data,
      input  fifo_rd_data, mem_full, mem_empty, mem_wr_err, mem_rd_err, mem_count
   );

   modport slave (
      input  mem_wr_en, mem_rd_en, fifo_wr_data,
      output fifo_rd_data, mem_full, mem_empty, mem_wr_err, mem_rd_err, mem_count
   );
endinterface

// File: rtl/fifo_mem_ctrl.sv
// Circular-buffer storage for the FIFO: register array, wrapping pointers,
// occupancy counter and registered status/error flags.
module fifo_mem_ctrl #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   fifo_mem_if.slave   bus
);
   localparam int          AW     = $clog2(DEPTH);
   localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [AW:0]      r_count;
   logic             r_full;
   logic             r_empty;
   logic             r_wr_err;
   logic             r_rd_err;
   logic [WIDTH-1:0] r_rd_data;

   logic             w_wr_ok;
   logic             w_rd_ok;
   logic [AW:0]      w_count_nxt;

   // A write into a full buffer is still legal when a read frees a slot this cycle.
   assign w_wr_ok = bus.mem_wr_en & (~r_full | bus.mem_rd_en);
   assign w_rd_ok = bus.mem_rd_en & ~r_empty;

   always_comb begin
      w_count_nxt = r_count;
      if (w_wr_ok && !w_rd_ok)
         w_count_nxt = r_count + 1'b1;
      else if (!w_wr_ok && w_rd_ok)
         w_count_nxt = r_count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst && w_wr_ok)
         r_mem[r_wr_ptr[AW-1:0]] <= bus.fifo_wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_full    <= 1'b0;
         r_empty   <= 1'b1;
         r_wr_err  <= 1'b0;
         r_rd_err  <= 1'b0;
         r_rd_data <= '0;
      end else begin
         if (w_wr_ok)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_ok) begin
            r_rd_ptr  <= r_rd_ptr + 1'b1;
            r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
         end
         r_count  <= w_count_nxt;
         r_full   <= (w_count_nxt == C_FULL);
         r_empty  <= (w_count_nxt == '0);
         r_wr_err <= bus.mem_wr_en & r_full & ~bus.mem_rd_en;
         r_rd_err <= bus.mem_rd_en & r_empty;
      end
   end

   assign bus.fifo_rd_data = r_rd_data;
   assign bus.mem_full     = r_full;
   assign bus.mem_empty    = r_empty;
   assign bus.mem_wr_err   = r_wr_err;
   assign bus.mem_rd_err   = r_rd_err;
   assign bus.mem_count    = r_count;
endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Directed bench for fifo_mem_ctrl: a queue model of the buffer predicts
// flags and counts, and a scoreboard holds the data each accepted read must return.
module tb_fifo_mem_ctrl;
   localparam int WIDTH = 32;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fifo_mem_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   fifo_mem_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [WIDTH-1:0] model [$];
   logic [WIDTH-1:0] q_exp [$];
   logic [WIDTH-1:0] last_rd = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One cycle of stimulus; expectations come from the queue model before the edge.
   task automatic cycle(input bit wr, input bit rd, input logic [WIDTH-1:0] d);
      int cnt;
      bit acc_wr, acc_rd, exp_wr_err, exp_rd_err;
      logic [WIDTH-1:0] exp_d;
      cnt        = model.size();
      acc_rd     = rd && (cnt > 0);
      acc_wr     = wr && ((cnt < DEPTH) || rd);
      exp_wr_err = wr && (cnt == DEPTH) && !rd;
      exp_rd_err = rd && (cnt == 0);
      if (acc_rd) q_exp.push_back(model.pop_front());
      if (acc_wr) model.push_back(d);
      bus.mem_wr_en    = wr;
      bus.mem_rd_en    = rd;
      bus.fifo_wr_data = d;
      tick();
      bus.mem_wr_en = 1'b0;
      bus.mem_rd_en = 1'b0;
      check("wr_err", 32'(bus.mem_wr_err), 32'(exp_wr_err));
      check("rd_err", 32'(bus.mem_rd_err), 32'(exp_rd_err));
      check("count",  32'(bus.mem_count),  32'(model.size()));
      check("full",   32'(bus.mem_full),   32'(model.size() == DEPTH));
      check("empty",  32'(bus.mem_empty),  32'(model.size() == 0));
      if (acc_rd) begin
         exp_d   = q_exp.pop_front();
         last_rd = exp_d;
         check("rd_data", bus.fifo_rd_data, exp_d);
      end else begin
         check("rd_hold", bus.fifo_rd_data, last_rd);
      end
   endtask

   initial begin
      bus.mem_wr_en    = 1'b0;
      bus.mem_rd_en    = 1'b0;
      bus.fifo_wr_data = '0;

      // Reset with a pending request that must be ignored
      bus.mem_rd_en = 1'b1;
      repeat (2) tick();
      bus.mem_rd_en = 1'b0;
      check("rst_count", 32'(bus.mem_count), 32'd0);
      check("rst_empty", 32'(bus.mem_empty), 32'd1);
      check("rst_full",  32'(bus.mem_full),  32'd0);
      check("rst_rdata", bus.fifo_rd_data,   32'd0);
      check("rst_rderr", 32'(bus.mem_rd_err), 32'd0);
      check("rst_wrerr", 32'(bus.mem_wr_err), 32'd0);
      #3 rst = 1'b0;
      repeat (2) cycle(0, 0, '0);

      // Fill A0..A7, then drain in order
      for (int i = 0; i < DEPTH; i++) cycle(1, 0, 32'hA0 + i);
      for (int i = 0; i < DEPTH; i++) cycle(0, 1, '0);
      cycle(0, 0, '0);

      // Full: rejected write, then read+write 0xB8 into freed slot, then drain
      for (int i = 0; i < DEPTH; i++) cycle(1, 0, 32'hC0 + i);
      cycle(1, 0, 32'hFF);
      cycle(1, 0, 32'hFF);
      cycle(1, 1, 32'hB8);
      for (int i = 0; i < DEPTH; i++) cycle(0, 1, '0);
      check("b8_last", last_rd, 32'hB8);

      // Empty: read+write 0x55, read rejected, write accepted
      cycle(1, 1, 32'h55);
      cycle(0, 1, '0);
      check("read_55", last_rd, 32'h55);

      // Three fill/drain passes across the pointer wrap, with mid-stream read+write
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < DEPTH - 1; i++) cycle(1, 0, $urandom);
         cycle(1, 1, $urandom);
         cycle(1, 0, $urandom);
         for (int i = 0; i < DEPTH; i++) cycle(0, 1, '0);
         cycle(0, 1, '0);
      end

      // Reset in the middle of a read
      for (int i = 0; i < 5; i++) cycle(1, 0, 32'hD0 + i);
      cycle(0, 1, '0);
      bus.mem_rd_en = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("mid_rst_count", 32'(bus.mem_count), 32'd0);
      check("mid_rst_empty", 32'(bus.mem_empty), 32'd1);
      check("mid_rst_full",  32'(bus.mem_full),  32'd0);
      check("mid_rst_rdata", bus.fifo_rd_data,   32'd0);
      model.delete();
      q_exp.delete();
      last_rd = '0;
      tick();
      bus.mem_rd_en = 1'b0;
      #3 rst = 1'b0;
      cycle(0, 1, '0);
      cycle(0, 0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/fifo_mem_ctrl.md
Name: fifo_mem_ctrl

Overview:
- Storage and pointer stage of the FIFO. Sits directly downstream of the FIFO write/read control logic.
- Consumes mem_wr_en, mem_rd_en and fifo_wr_data from that logic. Produces fifo_rd_data and the status flags mem_full, mem_empty, mem_wr_err and mem_rd_err, which the control logic turns into its system-facing signals.
- Implements a circular buffer: register array, wrapping pointers and an occupancy counter.

Parameters:
- WIDTH, 32, data word width in bits; matches WIDTH in FIFO_param_pkg.
- DEPTH, 8, number of entries; must be a power of 2 and ≥2.
- AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- mem_wr_en  input  1  write request for this cycle.
- mem_rd_en  input  1  read request for this cycle.
- fifo_wr_data  input  WIDTH  data written when a write is accepted.
- fifo_rd_data  output  WIDTH  registered read data.
- mem_full  output  1  occupancy == DEPTH.
- mem_empty  output  1  occupancy == 0.
- mem_wr_err  output  1  one-cycle pulse: write rejected.
- mem_rd_err  output  1  one-cycle pulse: read rejected.
- mem_count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset (async assert, sync-clean deassert):
  - wr_ptr = rd_ptr = 0; mem_count = 0.
  - mem_empty = 1, mem_full = 0.
  - mem_wr_err = mem_rd_err = 0; fifo_rd_data = 0.
  - Array contents are not reset.
- Pointers: AW+1 bits each.
  - Low AW bits index the array; MSB is the wrap bit.
  - Increment modulo 2^(AW+1).
  - Equal pointers → empty. Same low bits with differing MSB → full.
- Flags: mem_full and mem_empty are registered from next-state occupancy, so they are valid the cycle after the causing edge. mem_count is registered and consistent with the flags.
- Write acceptance, evaluated on current state: wr_ok = mem_wr_en & (!mem_full | mem_rd_en).
  - On wr_ok: array[wr_ptr[AW-1:0]] ← fifo_wr_data; wr_ptr++.
- Read acceptance: rd_ok = mem_rd_en & !mem_empty.
  - On rd_ok: fifo_rd_data ← array[rd_ptr[AW-1:0]]; rd_ptr++.
  - Latency: data is visible the cycle after rd_ok.
  - fifo_rd_data holds its value when there is no accepted read.
- Occupancy update: mem_count += wr_ok − rd_ok.
- Simultaneous read and write:
  - Full: the read is accepted and so is the write (the write lands in the freed slot). Count stays DEPTH, mem_full stays 1, no error.
  - Empty: the read is rejected (mem_rd_err pulses; no write-to-read bypass), the write is accepted, and count becomes 1.
  - Normal (not full, not empty): both accepted, count unchanged.
- Errors:
  - mem_wr_err = 1 in the cycle after mem_wr_en & mem_full & !mem_rd_en; the write is dropped and no state changes.
  - mem_rd_err = 1 in the cycle after mem_rd_en & mem_empty; pointers and fifo_rd_data are unchanged.
  - Both errors are single-cycle pulses; a sustained illegal request gives a pulse every cycle.
- Wrap-around: after DEPTH accepted writes the pointer low bits return to 0 and the MSB toggles. Ordering is strictly FIFO across wrap.
- Reset mid-operation: all state returns immediately to reset values; any in-flight read data is discarded.
- Pending requests are ignored while rst = 1.

Test Plan (WIDTH=32, DEPTH=8):
- Reset, then idle → mem_empty=1, mem_full=0, mem_count=0, fifo_rd_data=0, no error pulses.
- Write 0xA0..0xA7 over 8 cycles, then 8 reads → mem_full=1 after the 8th write. fifo_rd_data returns 0xA0..0xA7 in order, each one cycle after its read. Ends with mem_empty=1.
- While full, write 0xFF with no read → mem_wr_err pulses for 1 cycle, mem_count stays 8, and a later drain never returns 0xFF.
- While empty, read plus write 0x55 in the same cycle → mem_rd_err pulses, mem_count=1, and the next read returns 0x55.
- While full, read plus write 0xB8 in the same cycle → no error, mem_count stays 8. After 3 full fill/drain passes across the wrap, order is preserved and 0xB8 appears last.
- Fill 5 entries, assert rst mid-read → mem_count=0, mem_empty=1, fifo_rd_data=0 asynchronously. After deassert, a read gives mem_rd_err.
